// File: rtl/arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arb_pkg : shared arbiter types, state encoding and helpers         |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Up to 16 sources; OR-reduction keeps it cheap when the input is one-hot.
  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick : round-robin search starting after ptr, optional exclude  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl,
  output logic [IDX_W-1:0] pick,
  output logic             found
);

  localparam logic [IDX_W+1:0] c_n   = (IDX_W+2)'(N);
  localparam logic [IDX_W+1:0] c_one = (IDX_W+2)'(1);

  logic [N-1:0]     w_mask;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W+1:0] w_start;
  logic [IDX_W+1:0] w_off;
  logic [IDX_W+1:0] w_sum;

  always_comb begin
    w_mask = excl ? (req & ~(N'(1) << ptr)) : req;
    w_start = (IDX_W+2)'(ptr) + c_one;
    // Rotating the doubled vector puts requester ptr+1 at bit 0.
    w_dbl = {w_mask, w_mask} >> w_start;
    w_rot = w_dbl[N-1:0];
    found = 1'b0;
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found = 1'b1;
        w_off = (IDX_W+2)'(i);
      end
    end
    w_sum = w_start + w_off;
    if (w_sum >= c_n) w_sum = w_sum - c_n;
    pick = w_sum[IDX_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : N-way round-robin arbiter with optional hold limit    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 0,
  localparam int IDX_W    = (clog2(N) > 1) ? clog2(N) : 1,
  localparam int CNT_W    = (clog2(MAX_HOLD + 1) > 1) ? clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  state_t           r_state;
  logic [N-1:0]     r_gnt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld;

  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_busy;
  logic             w_limit;
  logic             w_can_inc;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_limit   = (MAX_HOLD != 0) && (r_cnt >= c_max);
  assign w_can_inc = (MAX_HOLD != 0) && (r_cnt < c_max);

  // While busy the owner is masked, so found means "someone else is waiting".
  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .excl  (w_busy),
    .pick  (w_pick),
    .found (w_found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= IDX_W'(N - 1);
      r_cnt   <= '0;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_BUSY;
            r_gnt   <= N'(1) << w_pick;
            r_idx   <= w_pick;
            r_ptr   <= w_pick;
            r_cnt   <= c_one;
            r_vld   <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (req[r_idx] && !(w_limit && w_found)) begin
            if (w_can_inc) r_cnt <= r_cnt + c_one;
          end else if (w_found) begin
            r_gnt <= N'(1) << w_pick;
            r_idx <= w_pick;
            r_ptr <= w_pick;
            r_cnt <= c_one;
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_vld   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rr_arbiter : directed checks for rr_arbiter (hold 0 and hold 4) |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req0;
  logic [3:0] req1;
  logic [3:0] gnt0;
  logic [3:0] gnt1;
  logic [1:0] idx0;
  logic [1:0] idx1;
  logic       vld0;
  logic       vld1;

  int total;
  int bad;

  rr_arbiter #(.N(4), .MAX_HOLD(0)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .req     (req0),
    .gnt     (gnt0),
    .gnt_idx (idx0),
    .gnt_vld (vld0)
  );

  rr_arbiter #(.N(4), .MAX_HOLD(4)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .req     (req1),
    .gnt     (gnt1),
    .gnt_idx (idx1),
    .gnt_vld (vld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req0  = '0;
    req1  = '0;

    // Test 1: reset state, single request, release
    tick();
    check("rst_gnt", gnt0, 4'b0000);
    check("rst_idx", {2'b00, idx0}, 4'd0);
    check("rst_vld", {3'b000, vld0}, 4'd0);
    rst  = 1'b1;
    req0 = 4'b0001;
    tick();
    check("t1_gnt", gnt0, 4'b0001);
    check("t1_idx", {2'b00, idx0}, 4'd0);
    check("t1_vld", {3'b000, vld0}, 4'd1);
    req0 = 4'b0000;
    tick();
    check("t1_rel_gnt", gnt0, 4'b0000);
    check("t1_rel_idx", {2'b00, idx0}, 4'd0);
    check("t1_rel_vld", {3'b000, vld0}, 4'd0);

    // Test 2: fresh reset so requester 0 leads; each owner holds 3 cycles
    rst = 1'b0;
    tick();
    rst  = 1'b1;
    req0 = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check("t2_gnt", gnt0, 4'b0001 << k);
        check("t2_idx", {2'b00, idx0}, 4'(k));
      end
      req0[k] = 1'b0;
    end
    tick();
    check("t2_idle_gnt", gnt0, 4'b0000);
    check("t2_idle_idx", {2'b00, idx0}, 4'd3);

    // Test 5: simultaneous drop/raise, then wrap from ptr=3 to 0
    req0 = 4'b0100;
    tick();
    check("t5_g2", gnt0, 4'b0100);
    req0 = 4'b1000;
    tick();
    check("t5_g3", gnt0, 4'b1000);
    req0 = 4'b0000;
    tick();
    check("t5_idle", gnt0, 4'b0000);
    check("t5_idle_idx", {2'b00, idx0}, 4'd3);
    req0 = 4'b1001;
    tick();
    check("t5_wrap", gnt0, 4'b0001);

    // Test 3: hold limit 4 alternates two steady requesters
    req1 = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t3_gnt", gnt1, ((i / 4) % 2 == 1) ? 4'b0010 : 4'b0001);
    end
    req1 = 4'b0000;
    tick();
    check("t3_idle", gnt1, 4'b0000);

    // Test 4: lone requester keeps grant past the hold limit
    req1 = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_gnt", gnt1, 4'b0100);
      check("t4_vld", {3'b000, vld1}, 4'd1);
    end
    req1 = 4'b0000;
    tick();
    check("t4_idle", gnt1, 4'b0000);

    // Test 6: asynchronous reset while requester 1 owns the grant
    req0 = 4'b0010;
    tick();
    check("t6_pre_gnt", gnt0, 4'b0010);
    check("t6_pre_idx", {2'b00, idx0}, 4'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_gnt", gnt0, 4'b0000);
    check("t6_async_vld", {3'b000, vld0}, 4'd0);
    check("t6_async_idx", {2'b00, idx0}, 4'd0);
    tick();
    rst  = 1'b1;
    req0 = 4'b1010;
    tick();
    check("t6_post_gnt", gnt0, 4'b0010);
    check("t6_post_idx", {2'b00, idx0}, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
